// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA mode controller.
// Reset thresholds, register map and FSM encoding.
package vga_pkg;

  typedef logic [10:0] thr_t;
  typedef thr_t [7:0] thr_set_t;

  localparam thr_t RST_PIXEL   = 11'd640;
  localparam thr_t RST_EOHFP   = 11'd664;
  localparam thr_t RST_EOHSYNC = 11'd696;
  localparam thr_t RST_EOLINE  = 11'd742;
  localparam thr_t RST_LINE    = 11'd480;
  localparam thr_t RST_EOVFP   = 11'd483;
  localparam thr_t RST_EOVSYNC = 11'd488;
  localparam thr_t RST_EOFRAME = 11'd502;

  // vertical counter in vga_timing is 10 bits
  localparam thr_t VMAX = 11'd1023;

  localparam logic [3:0] ADDR_CTRL   = 4'd8;
  localparam logic [3:0] ADDR_STATUS = 4'd9;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_COMMIT = 1;
  localparam int ST_PEND     = 0;
  localparam int ST_ERR      = 1;
  localparam int ST_EN       = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VS,
    APPLY,
    HOLD
  } state_t;

endpackage

// File: rtl/vga_mode_ctrl_if.sv
// Register bus between the SoC and vga_mode_ctrl.
// Single-cycle strobes, one-cycle registered acknowledge.
interface vga_mode_ctrl_if;
  logic        cfg_we;
  logic        cfg_re;
  logic [3:0]  cfg_addr;
  logic [10:0] cfg_wdata;
  logic [10:0] cfg_rdata;
  logic        cfg_ack;

  modport master (
    output cfg_we, cfg_re, cfg_addr, cfg_wdata,
    input  cfg_rdata, cfg_ack
  );

  modport slave (
    input  cfg_we, cfg_re, cfg_addr, cfg_wdata,
    output cfg_rdata, cfg_ack
  );
endinterface

// File: rtl/vga_mode_check.sv
// Combinational validator for a shadow timing set.
// Checks threshold ordering and the vertical counter range.
module vga_mode_check
  import vga_pkg::*;
(
  input  thr_set_t thr,
  output logic     valid
);
  logic h_ok;
  logic v_ok;

  assign h_ok = (thr[0] <= thr[1])
             && (thr[1] <  thr[2])
             && (thr[2] <  thr[3]);
  assign v_ok = (thr[4] <= thr[5])
             && (thr[5] <  thr[6])
             && (thr[6] <  thr[7]);
  assign valid = h_ok && v_ok && (thr[7] <= VMAX);
endmodule

// File: rtl/vga_mode_ctrl.sv
// Shadow/active mode registers for vga_timing with validated
// commit, vsync-aligned apply and a generator reset pulse.
module vga_mode_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter thr_t DEF_PIXEL   = RST_PIXEL,
  parameter thr_t DEF_EOHFP   = RST_EOHFP,
  parameter thr_t DEF_EOHSYNC = RST_EOHSYNC,
  parameter thr_t DEF_EOLINE  = RST_EOLINE,
  parameter thr_t DEF_LINE    = RST_LINE,
  parameter thr_t DEF_EOVFP   = RST_EOVFP,
  parameter thr_t DEF_EOVSYNC = RST_EOVSYNC,
  parameter thr_t DEF_EOFRAME = RST_EOFRAME
) (
  input  logic pixel_clk,
  input  logic rst,
  vga_mode_ctrl_if.slave cfg,
  input  logic vsync_i,
  output thr_t pixel_num,
  output thr_t eohfp_num,
  output thr_t eohsync_num,
  output thr_t eoline_num,
  output thr_t line_num,
  output thr_t eovfp_num,
  output thr_t eovsync_num,
  output thr_t eoframe_num,
  output logic tgen_rst,
  output logic mode_irq
);
  thr_set_t   defs;
  thr_set_t   shadow;
  thr_set_t   active;
  state_t     state;
  state_t     nxt;
  logic       enable;
  logic       pending;
  logic       cfg_err;
  logic       vsync_q;
  logic [3:0] cnt;
  logic       valid;
  logic       wr_thr;
  logic       wr_ctrl;
  logic       commit;
  logic       vs_fall;
  logic       en_off;
  logic       en_nxt;
  logic       acc;
  logic       rej;
  thr_t       rd;

  assign defs = {DEF_EOFRAME, DEF_EOVSYNC,
                 DEF_EOVFP, DEF_LINE,
                 DEF_EOLINE, DEF_EOHSYNC,
                 DEF_EOHFP, DEF_PIXEL};

  vga_mode_check u_check (
    .thr   (shadow),
    .valid (valid)
  );

  assign wr_thr  = cfg.cfg_we && !cfg.cfg_addr[3];
  assign wr_ctrl = cfg.cfg_we
                && (cfg.cfg_addr == ADDR_CTRL);
  assign commit  = wr_ctrl && !pending
                && cfg.cfg_wdata[CTRL_COMMIT];
  assign vs_fall = vsync_q && !vsync_i;
  assign en_off  = wr_ctrl && !cfg.cfg_wdata[CTRL_EN];
  assign en_nxt  = wr_ctrl ? cfg.cfg_wdata[CTRL_EN]
                           : enable;

  always_comb begin
    nxt = state;
    acc = 1'b0;
    rej = 1'b0;
    unique case (state)
      IDLE: begin
        if (commit && !valid) begin
          rej = 1'b1;
        end else if (commit) begin
          acc = 1'b1;
          nxt = en_nxt ? WAIT_VS : APPLY;
        end
      end
      WAIT_VS: begin
        if (vs_fall || en_off || !enable)
          nxt = APPLY;
      end
      APPLY: nxt = HOLD;
      HOLD: begin
        if (cnt <= 4'd1)
          nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    rd = '0;
    if (!cfg.cfg_addr[3]) begin
      rd = shadow[cfg.cfg_addr[2:0]];
    end else if (cfg.cfg_addr == ADDR_CTRL) begin
      rd[CTRL_EN] = enable;
    end else if (cfg.cfg_addr == ADDR_STATUS) begin
      rd[ST_PEND] = pending;
      rd[ST_ERR]  = cfg_err;
      rd[ST_EN]   = enable;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (state == APPLY)
        cnt <= 4'(HOLD_CYCLES);
      else if (state == HOLD)
        cnt <= cnt - 4'd1;
    end
  end

  // Active set and irq switch on the edge that enters APPLY.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      shadow        <= defs;
      active        <= defs;
      enable        <= 1'b1;
      pending       <= 1'b0;
      cfg_err       <= 1'b0;
      vsync_q       <= 1'b1;
      tgen_rst      <= 1'b1;
      mode_irq      <= 1'b0;
      cfg.cfg_ack   <= 1'b0;
      cfg.cfg_rdata <= '0;
    end else begin
      vsync_q       <= vsync_i;
      cfg.cfg_ack   <= cfg.cfg_we || cfg.cfg_re;
      cfg.cfg_rdata <= cfg.cfg_re ? rd : '0;
      if (wr_thr && !pending)
        shadow[cfg.cfg_addr[2:0]] <= cfg.cfg_wdata;
      if (wr_ctrl)
        enable <= cfg.cfg_wdata[CTRL_EN];
      if (rej)
        cfg_err <= 1'b1;
      if (acc) begin
        cfg_err <= 1'b0;
        pending <= 1'b1;
      end
      if (state == APPLY)
        pending <= 1'b0;
      mode_irq <= (nxt == APPLY);
      if (nxt == APPLY)
        active <= shadow;
      tgen_rst <= !en_nxt || (nxt == APPLY)
               || (nxt == HOLD);
    end
  end

  assign pixel_num   = active[0];
  assign eohfp_num   = active[1];
  assign eohsync_num = active[2];
  assign eoline_num  = active[3];
  assign line_num    = active[4];
  assign eovfp_num   = active[5];
  assign eovsync_num = active[6];
  assign eoframe_num = active[7];
endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Self-checking bench for vga_mode_ctrl.
// Directed corner sequences, a vector table and a random model.
module tb_vga_mode_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        vsync_i;
  logic [10:0] pixel_num, eohfp_num, eohsync_num;
  logic [10:0] eoline_num, line_num, eovfp_num;
  logic [10:0] eovsync_num, eoframe_num;
  logic        tgen_rst;
  logic        mode_irq;

  int checks = 0;
  int failures = 0;

  vga_mode_ctrl_if cfg ();

  vga_mode_ctrl dut (
    .pixel_clk   (clk),
    .rst         (rst),
    .cfg         (cfg),
    .vsync_i     (vsync_i),
    .pixel_num   (pixel_num),
    .eohfp_num   (eohfp_num),
    .eohsync_num (eohsync_num),
    .eoline_num  (eoline_num),
    .line_num    (line_num),
    .eovfp_num   (eovfp_num),
    .eovsync_num (eovsync_num),
    .eoframe_num (eoframe_num),
    .tgen_rst    (tgen_rst),
    .mode_irq    (mode_irq)
  );

  always #5 clk = ~clk;

  typedef logic [7:0][10:0] set_t;
  typedef struct packed {
    set_t s;
    logic ok;
  } vec_t;

  set_t m_shadow;
  set_t m_active;
  logic m_en;
  logic m_err;
  logic m_pend;
  set_t def_set;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  function automatic set_t mk(
    int p, int a, int b, int c,
    int l, int e, int f, int g);
    set_t s;
    s[0] = 11'(p); s[1] = 11'(a);
    s[2] = 11'(b); s[3] = 11'(c);
    s[4] = 11'(l); s[5] = 11'(e);
    s[6] = 11'(f); s[7] = 11'(g);
    return s;
  endfunction

  // Each group: first <= second, then strictly rising.
  function automatic bit model_ok(set_t s);
    for (int g = 0; g < 2; g++) begin
      if (s[4*g] > s[4*g+1]) return 1'b0;
      for (int k = 1; k < 3; k++)
        if (s[4*g+k] >= s[4*g+k+1]) return 1'b0;
    end
    return int'(s[7]) <= 1023;
  endfunction

  function automatic logic [10:0] model_read(logic [3:0] a);
    if (a < 4'd8) return m_shadow[a[2:0]];
    if (a == 4'd8) return {10'd0, m_en};
    if (a == 4'd9) return {8'd0, m_en, m_err, m_pend};
    return 11'd0;
  endfunction

  function automatic logic [10:0] outv(int i);
    case (i)
      0: return pixel_num;
      1: return eohfp_num;
      2: return eohsync_num;
      3: return eoline_num;
      4: return line_num;
      5: return eovfp_num;
      6: return eovsync_num;
      default: return eoframe_num;
    endcase
  endfunction

  task automatic check_outs(input string nm, input set_t e);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_out%0d", nm, i), outv(i), e[i]);
  endtask

  task automatic bus(input bit w, input bit r,
                     input logic [3:0] a,
                     input logic [10:0] d,
                     output logic [10:0] q);
    cfg.cfg_we = w;
    cfg.cfg_re = r;
    cfg.cfg_addr = a;
    cfg.cfg_wdata = d;
    @(negedge clk);
    cfg.cfg_we = 1'b0;
    cfg.cfg_re = 1'b0;
    q = cfg.cfg_rdata;
    check("ack", cfg.cfg_ack, 1);
  endtask

  task automatic wr(input logic [3:0] a, input int d);
    logic [10:0] q;
    bus(1'b1, 1'b0, a, 11'(d), q);
  endtask

  task automatic rd(input logic [3:0] a, output logic [10:0] q);
    bus(1'b0, 1'b1, a, 11'd0, q);
  endtask

  task automatic write_set(input set_t s);
    for (int i = 0; i < 8; i++) wr(4'(i), int'(s[i]));
  endtask

  // Commit with enable=0 so APPLY follows immediately.
  task automatic commit_check(input set_t s, input bit ok,
                              input string nm);
    logic [10:0] q;
    write_set(s);
    m_shadow = s;
    wr(4'd8, 2);
    repeat (6) @(negedge clk);
    if (ok) m_active = s;
    m_err = !ok;
    rd(4'd9, q);
    check({nm, "_status"}, q, model_read(4'd9));
    check({nm, "_tgen"}, tgen_rst, 1);
    check_outs(nm, m_active);
  endtask

  task automatic model_reset();
    m_shadow = def_set;
    m_active = def_set;
    m_en = 1'b1;
    m_err = 1'b0;
    m_pend = 1'b0;
  endtask

  vec_t tbl [9];

  initial begin
    logic [10:0] q;
    int hi, irqs;
    set_t s;

    def_set = mk(640, 664, 696, 742, 480, 483, 488, 502);
    tbl[0] = '{s: mk(640,656,752,800,480,490,492,525), ok: 1};
    tbl[1] = '{s: mk(640,640,641,642,480,480,481,482), ok: 1};
    tbl[2] = '{s: mk(640,639,700,800,480,490,492,525), ok: 0};
    tbl[3] = '{s: mk(640,656,800,800,480,490,492,525), ok: 0};
    tbl[4] = '{s: mk(1000,1001,1002,1003,1000,1010,1020,1023), ok: 1};
    tbl[5] = '{s: mk(1000,1001,1002,1003,1000,1010,1020,1024), ok: 0};
    tbl[6] = '{s: mk(640,656,752,800,480,490,490,525), ok: 0};
    tbl[7] = '{s: mk(2000,2001,2046,2047,480,483,488,502), ok: 1};
    tbl[8] = '{s: mk(640,656,752,800,480,479,492,525), ok: 0};

    rst = 1'b1;
    vsync_i = 1'b1;
    cfg.cfg_we = 1'b0;
    cfg.cfg_re = 1'b0;
    cfg.cfg_addr = '0;
    cfg.cfg_wdata = '0;
    model_reset();

    // reset state
    repeat (3) @(negedge clk);
    check("rst_tgen", tgen_rst, 1);
    check("rst_ack", cfg.cfg_ack, 0);
    check("rst_rdata", cfg.cfg_rdata, 0);
    check("rst_irq", mode_irq, 0);
    check_outs("rst", def_set);
    rst = 1'b0;
    @(negedge clk);
    check("rel_tgen", tgen_rst, 0);
    rd(4'd9, q);
    check("rst_status", q, 11'h4);

    // vsync-aligned apply
    s = mk(800, 840, 968, 1056, 600, 601, 605, 628);
    write_set(s);
    rd(4'd3, q);
    check("shadow_rb", q, 1056);
    wr(4'd8, 3);
    rd(4'd9, q);
    check("pend_status", q, 11'h5);
    check_outs("pend", def_set);
    wr(4'd0, 320);
    rd(4'd0, q);
    check("pend_drop", q, 800);
    wr(4'd8, 3);
    rd(4'd9, q);
    check("pend_status2", q, 11'h5);
    vsync_i = 1'b0;
    @(negedge clk);
    check("vs_irq", mode_irq, 1);
    check_outs("vs", s);
    hi = int'(tgen_rst);
    irqs = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      hi += int'(tgen_rst);
      irqs += int'(mode_irq);
    end
    check("vs_tgen_len", hi, 3);
    check("vs_irq_cnt", irqs, 1);
    vsync_i = 1'b1;
    rd(4'd9, q);
    check("vs_status", q, 11'h4);

    // invalid commit, then valid commit clears error
    wr(4'd1, 664);
    wr(4'd2, 664);
    wr(4'd8, 3);
    rd(4'd9, q);
    check("err_status", q, 11'h6);
    check("err_pix", pixel_num, 800);
    wr(4'd0, 640);
    wr(4'd2, 696);
    wr(4'd3, 800);
    wr(4'd8, 3);
    rd(4'd9, q);
    check("fix_status", q, 11'h5);
    vsync_i = 1'b0;
    repeat (6) @(negedge clk);
    vsync_i = 1'b1;
    check("fix_pix", pixel_num, 640);
    check("fix_eol", eoline_num, 800);
    check("fix_eof", eoframe_num, 628);

    // disable during WAIT_VS forces apply
    wr(4'd7, 620);
    wr(4'd8, 3);
    wr(4'd8, 0);
    check("dis_irq", mode_irq, 1);
    check("dis_eof", eoframe_num, 620);
    repeat (10) @(negedge clk);
    check("dis_tgen", tgen_rst, 1);
    wr(4'd8, 1);
    check("en_tgen", tgen_rst, 0);

    // reset during HOLD
    wr(4'd7, 630);
    wr(4'd8, 3);
    vsync_i = 1'b0;
    @(negedge clk);
    check("hr_irq", mode_irq, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("hr_tgen", tgen_rst, 1);
    check("hr_irq0", mode_irq, 0);
    check_outs("hr", def_set);
    rst = 1'b0;
    vsync_i = 1'b1;
    @(negedge clk);
    model_reset();
    rd(4'd9, q);
    check("hr_status", q, 11'h4);
    rd(4'd7, q);
    check("hr_shadow", q, 502);

    // table of validation vectors
    wr(4'd8, 0);
    m_en = 1'b0;
    for (int i = 0; i < 9; i++)
      commit_check(tbl[i].s, tbl[i].ok,
                   $sformatf("tbl%0d", i));

    // random sets against the model
    for (int n = 0; n < 30; n++) begin
      int b;
      b = $urandom_range(0, 1900);
      s[0] = 11'(b);
      s[1] = s[0] + 11'($urandom_range(0, 2));
      s[2] = s[1] + 11'($urandom_range(0, 2));
      s[3] = s[2] + 11'($urandom_range(0, 3));
      b = $urandom_range(0, 1015);
      s[4] = 11'(b);
      s[5] = s[4] + 11'($urandom_range(0, 2));
      s[6] = s[5] + 11'($urandom_range(0, 2));
      s[7] = s[6] + 11'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0)
        s[7] = 11'($urandom_range(1020, 1030));
      if ($urandom_range(0, 4) == 0)
        s[$urandom_range(0, 7)] = 11'($urandom_range(0, 2047));
      commit_check(s, model_ok(s), $sformatf("rnd%0d", n));
    end

    // random bus traffic, including read+write together
    for (int n = 0; n < 60; n++) begin
      logic [3:0] a;
      logic [10:0] d, e;
      bit w, r;
      a = 4'($urandom_range(0, 15));
      w = 1'($urandom_range(0, 1));
      r = !w || ($urandom_range(0, 1) == 1);
      d = 11'($urandom_range(0, 2047));
      if (a == 4'd8) d = d & 11'h1;
      e = model_read(a);
      bus(w, r, a, d, q);
      if (r) check("bus_rd", q, e);
      if (w && a < 4'd8) m_shadow[a[2:0]] = d;
      if (w && a == 4'd8) m_en = d[0];
      check("bus_tgen", tgen_rst, !m_en);
    end
    check_outs("final", m_active);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/vga_mode_ctrl.md
# vga_mode_ctrl

Configuration controller for the `vga_timing` generator. It holds a CPU-writable shadow set of the eight horizontal and vertical timing thresholds and validates each new set on a commit request. It applies an accepted set atomically at the next vsync start, then pulses the generator's reset so its counters restart cleanly in the new mode. It sits between the SoC register bus and the `vga_timing` configuration and reset inputs.

## Interface
- `HOLD_CYCLES`, default 2: cycles `tgen_rst` stays high after a mode is applied (1..15).
- `DEF_PIXEL`, `DEF_EOHFP`, `DEF_EOHSYNC`, `DEF_EOLINE`, default 640/664/696/742: reset horizontal thresholds.
- `DEF_LINE`, `DEF_EOVFP`, `DEF_EOVSYNC`, `DEF_EOFRAME`, default 480/483/488/502: reset vertical thresholds.

Ports:
- `pixel_clk` in 1: the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `cfg_we` in 1: single-cycle write strobe.
- `cfg_re` in 1: single-cycle read strobe.
- `cfg_addr` in 4: register index.
- `cfg_wdata` in 11: write data.
- `cfg_rdata` out 11: read data, valid while `cfg_ack` is high.
- `cfg_ack` out 1: one-cycle acknowledge.
- `vsync_i` in 1: active-low vsync from `vga_timing`.
- `pixel_num`, `eohfp_num`, `eohsync_num`, `eoline_num`, `line_num`, `eovfp_num`, `eovsync_num`, `eoframe_num` out 11 each: active thresholds driven to `vga_timing`.
- `tgen_rst` out 1: reset to `vga_timing`.
- `mode_irq` out 1: one-cycle pulse when a mode is applied.

## Operation
- Register map, values right-aligned:
  - 0..7: shadow thresholds, in port order above, read/write.
  - 8: CTRL. Bit0 `enable`, read/write, resets to 1. Bit1 `commit`, write-1 request, reads 0.
  - 9: STATUS, read-only. Bit0 `pending`, bit1 `cfg_err` (sticky), bit2 `enable`.
  - 10..15: reads 0, writes ignored.
- Validation, done in the commit cycle:
  - `pixel <= eohfp < eohsync < eoline` and `line <= eovfp < eovsync < eoframe`.
  - `eoframe <= 1023`, because the vertical counter is 10 bits.
  - All comparisons are unsigned 11-bit.
- FSM states: IDLE, WAIT_VS, APPLY, HOLD.
  - IDLE, on a commit write: if validation fails, set `cfg_err` and stay in IDLE. Otherwise clear `cfg_err` and set `pending`. Go to APPLY if `enable`=0, else go to WAIT_VS.
  - WAIT_VS → APPLY on a vsync falling edge (`vsync_q`=1, `vsync_i`=0).
  - APPLY, one cycle: copy shadow to active, clear `pending`, pulse `mode_irq`, load the hold counter with `HOLD_CYCLES`. Next state HOLD.
  - HOLD: decrement; go to IDLE when the counter reaches 0.
- `tgen_rst` is registered: 1 when `rst`, or `enable`=0, or state is APPLY/HOLD.
- While `pending`=1: writes to 0..7 are acked but dropped, and further commit writes are ignored.
- Writing `enable`=0 while in WAIT_VS forces APPLY on the next cycle.
- `cfg_we` and `cfg_re` together: the write is performed and `cfg_rdata` returns the pre-write value.

## Timing
- Reset values:
  - Active and shadow thresholds = `DEF_*`.
  - `tgen_rst`=1; `cfg_ack`=0; `cfg_rdata`=0; `mode_irq`=0.
  - `pending`=0; `cfg_err`=0; `enable`=1; `vsync_q`=1; state IDLE.
- `tgen_rst` falls on the first clock edge after `rst` deasserts.
- Bus latency: strobe in cycle N → `cfg_ack` and `cfg_rdata` in N+1. Back-to-back strobes are allowed every cycle.
- Applying a mode:
  - Vsync fall sampled at edge N → APPLY in N+1, active outputs change and `mode_irq`=1 in N+1.
  - `tgen_rst` is high for `HOLD_CYCLES`+1 cycles starting at N+1.
- Commit with `enable`=0: APPLY runs the cycle after the commit write.
- `rst` mid-operation returns everything to reset values and discards any pending commit.

## Structure
- Shared `vga_pkg` holds:
  - the `DEF_*` values;
  - register address constants and CTRL/STATUS bit positions;
  - the FSM state encoding.
- Sub-module `vga_mode_check`: combinational validator taking the 8 shadow values and returning a `valid` flag.

## Test plan
- Reset, no writes → outputs 640/664/696/742/480/483/488/502; `tgen_rst` low one cycle after reset; read addr 9 returns 0x4.
- Write 800/840/968/1056/600/601/605/628, then commit with `vsync_i` high → `pending`=1 and outputs unchanged. Drive `vsync_i` 1→0 → new values and `mode_irq` one cycle later, `tgen_rst` high 3 cycles.
- Commit with `eohsync`=`eohfp`=664 → `cfg_err`=1, no change; a later valid commit clears `cfg_err`.
- While pending, write addr 0 = 320 → read addr 0 still 800; a second commit is ignored.
- Write CTRL=0 during WAIT_VS → apply on the next cycle, `tgen_rst` stays high until CTRL=1.
- Assert `rst` while in HOLD → defaults restored, `pending`=0, `tgen_rst`=1.
